unidade_hazard_forward: RTL and testbench

Pipeline hazard controller for the 16-bit processor. Tracks the destination register of every in-flight instruction in a shadow pipeline (EX, MEM, WB) and drives the `forwardA`/`forwardB` selects of the EX-stage operand muxes. It also detects load-use hazards and inserts one-cycle stalls. It handles taken-branch flushes, and keeps a saturating stall counter for performance debug. It sits beside the ID stage and advances in lockstep with the pipeline registers.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/unidade_hazard_forward_if.sv | 34 +++
 rtl/seletor_forward.sv | 21 ++
 rtl/unidade_hazard_forward.sv | 86 ++++++++
 tb/tb_unidade_hazard_forward.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forward-select encodings, register index width and the shadow-entry record.
package pipeline_pkg;

  localparam int REG_BITS = 4;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] dest;
    logic                writes;
    logic                isLoad;
  } sombra_t;

  // r0 is hardwired to zero, so it never needs forwarding.
  function automatic logic produz(sombra_t s, logic [REG_BITS-1:0] r, logic usa);
    return s.valid && s.writes && (s.dest == r) && (r != '0) && usa;
  endfunction

endpackage

// File: rtl/unidade_hazard_forward_if.sv
// ID-stage instruction info into the hazard unit, stall/flush/forward controls back out.
interface unidade_hazard_forward_if #(
  parameter int REG_BITS  = 4,
  parameter int CONT_BITS = 16
);
  logic                 valido_ID;
  logic [REG_BITS-1:0]  regR1_ID;
  logic [REG_BITS-1:0]  regR2_ID;
  logic                 usaR1_ID;
  logic                 usaR2_ID;
  logic [REG_BITS-1:0]  regDest_ID;
  logic                 escreveReg_ID;
  logic                 leMem_ID;
  logic                 desvioTomado;
  logic [1:0]           forwardA;
  logic [1:0]           forwardB;
  logic                 pcEscreve;
  logic                 ifidEscreve;
  logic                 bolhaEX;
  logic                 flushIFID;
  logic [CONT_BITS-1:0] contaStalls;

  modport master (
    output valido_ID, regR1_ID, regR2_ID, usaR1_ID, usaR2_ID, regDest_ID,
           escreveReg_ID, leMem_ID, desvioTomado,
    input  forwardA, forwardB, pcEscreve, ifidEscreve, bolhaEX, flushIFID, contaStalls
  );

  modport slave (
    input  valido_ID, regR1_ID, regR2_ID, usaR1_ID, usaR2_ID, regDest_ID,
           escreveReg_ID, leMem_ID, desvioTomado,
    output forwardA, forwardB, pcEscreve, ifidEscreve, bolhaEX, flushIFID, contaStalls
  );
endinterface

// File: rtl/seletor_forward.sv
// Combinational forward select for one source operand; the youngest producer (sEX) wins over sMEM.
module seletor_forward
  import pipeline_pkg::*;
(
  input  logic [REG_BITS-1:0] reg_i,
  input  logic                usa_i,
  input  sombra_t             sEX_i,
  input  sombra_t             sMEM_i,
  output logic [1:0]          sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (produz(sEX_i, reg_i, usa_i)) begin
      sel_o = FWD_EXMEM;
    end else if (produz(sMEM_i, reg_i, usa_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/unidade_hazard_forward.sv
// Hazard/forward controller: shadow EX/MEM/WB destination tracking, registered forward selects,
// one-cycle load-use stall, taken-branch flush and a saturating stall counter.
module unidade_hazard_forward #(
  parameter int REG_BITS  = 4,
  parameter int CONT_BITS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  unidade_hazard_forward_if.slave  hf
);
  import pipeline_pkg::*;

  sombra_t              sEX_q, sEX_d, sMEM_q, sWB_q;
  logic [1:0]           fwdA_q, fwdA_d, fwdB_q, fwdB_d;
  logic [1:0]           selA, selB;
  logic [CONT_BITS-1:0] cont_q, cont_d;
  logic                 hazard, stall, bolha;

  seletor_forward u_sel_a (
    .reg_i  (hf.regR1_ID),
    .usa_i  (hf.usaR1_ID),
    .sEX_i  (sEX_q),
    .sMEM_i (sMEM_q),
    .sel_o  (selA)
  );

  seletor_forward u_sel_b (
    .reg_i  (hf.regR2_ID),
    .usa_i  (hf.usaR2_ID),
    .sEX_i  (sEX_q),
    .sMEM_i (sMEM_q),
    .sel_o  (selB)
  );

  always_comb begin
    hazard = hf.valido_ID && sEX_q.valid && sEX_q.isLoad &&
             (produz(sEX_q, hf.regR1_ID, hf.usaR1_ID) ||
              produz(sEX_q, hf.regR2_ID, hf.usaR2_ID));
    // A taken branch discards the ID instruction, so its hazard never stalls.
    stall  = hazard && !hf.desvioTomado;
    bolha  = hazard || hf.desvioTomado;

    sEX_d = '0;
    if (!bolha) begin
      sEX_d.valid  = hf.valido_ID;
      sEX_d.dest   = hf.regDest_ID;
      sEX_d.writes = hf.escreveReg_ID;
      sEX_d.isLoad = hf.leMem_ID;
    end

    fwdA_d = bolha ? FWD_REG : selA;
    fwdB_d = bolha ? FWD_REG : selB;

    cont_d = cont_q;
    if (stall && (cont_q != '1)) begin
      cont_d = cont_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sEX_q  <= '0;
      sMEM_q <= '0;
      sWB_q  <= '0;
      fwdA_q <= FWD_REG;
      fwdB_q <= FWD_REG;
      cont_q <= '0;
    end else begin
      sEX_q  <= sEX_d;
      sMEM_q <= sEX_q;
      sWB_q  <= sMEM_q;
      fwdA_q <= fwdA_d;
      fwdB_q <= fwdB_d;
      cont_q <= cont_d;
    end
  end

  assign hf.forwardA    = fwdA_q;
  assign hf.forwardB    = fwdB_q;
  assign hf.pcEscreve   = !stall;
  assign hf.ifidEscreve = !stall;
  assign hf.bolhaEX     = bolha;
  assign hf.flushIFID   = hf.desvioTomado;
  assign hf.contaStalls = cont_q;

endmodule

// File: tb/tb_unidade_hazard_forward.sv
// Bench for unidade_hazard_forward: directed program fragments plus random instruction streams,
// checked each cycle against an in-bench model of in-flight instructions.
module tb_unidade_hazard_forward;

  localparam int RB = 4;
  localparam int CB = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unidade_hazard_forward_if #(.REG_BITS(RB), .CONT_BITS(CB)) hf ();

  unidade_hazard_forward #(.REG_BITS(RB), .CONT_BITS(CB)) dut (
    .clock (clock),
    .reset (reset),
    .hf    (hf.slave)
  );

  // Model: instructions in flight, index 0 = in EX, 1 = in MEM, 2 = in WB.
  int m_v[3], m_d[3], m_w[3], m_l[3];
  int m_fa, m_fb, m_cnt;

  int errors = 0;
  int checks = 0;
  int s_pc, s_ifid, s_bolha, s_flush;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int writer_in(input int st, input int r, input int u);
    return (u != 0 && r != 0 && m_v[st] != 0 && m_w[st] != 0 && m_d[st] == r) ? 1 : 0;
  endfunction

  function automatic int exp_fwd(input int r, input int u);
    if (writer_in(0, r, u) != 0) return 2;
    if (writer_in(1, r, u) != 0) return 1;
    return 0;
  endfunction

  // One pipeline cycle: drive ID, check combinational controls, then registered state.
  task automatic step(input int rst, input int v, input int r1, input int u1, input int r2,
                      input int u2, input int rd, input int wr, input int ld, input int br);
    int haz, bub, nfa, nfb;
    reset            = 1'(rst);
    hf.valido_ID     = 1'(v);
    hf.regR1_ID      = RB'(r1);
    hf.usaR1_ID      = 1'(u1);
    hf.regR2_ID      = RB'(r2);
    hf.usaR2_ID      = 1'(u2);
    hf.regDest_ID    = RB'(rd);
    hf.escreveReg_ID = 1'(wr);
    hf.leMem_ID      = 1'(ld);
    hf.desvioTomado  = 1'(br);
    #1;
    haz = (v != 0 && m_v[0] != 0 && m_l[0] != 0 &&
           (writer_in(0, r1, u1) != 0 || writer_in(0, r2, u2) != 0)) ? 1 : 0;
    bub = (haz != 0 || br != 0) ? 1 : 0;
    s_pc = int'(hf.pcEscreve);   s_ifid  = int'(hf.ifidEscreve);
    s_bolha = int'(hf.bolhaEX);  s_flush = int'(hf.flushIFID);
    chk("pcEscreve",   s_pc,    (haz != 0 && br == 0) ? 0 : 1);
    chk("ifidEscreve", s_ifid,  (haz != 0 && br == 0) ? 0 : 1);
    chk("bolhaEX",     s_bolha, bub);
    chk("flushIFID",   s_flush, br != 0 ? 1 : 0);
    nfa = bub != 0 ? 0 : exp_fwd(r1, u1);
    nfb = bub != 0 ? 0 : exp_fwd(r2, u2);
    @(posedge clock);
    if (rst != 0) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_d[i] = 0; m_w[i] = 0; m_l[i] = 0;
      end
      m_fa = 0; m_fb = 0; m_cnt = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_w[i] = m_w[i-1]; m_l[i] = m_l[i-1];
      end
      m_v[0] = bub != 0 ? 0 : (v != 0 ? 1 : 0);
      m_d[0] = rd; m_w[0] = wr; m_l[0] = ld;
      m_fa = nfa; m_fb = nfb;
      if (haz != 0 && br == 0 && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clock);
    chk("forwardA",    int'(hf.forwardA),    m_fa);
    chk("forwardB",    int'(hf.forwardB),    m_fb);
    chk("contaStalls", int'(hf.contaStalls), m_cnt);
  endtask

  task automatic alu(input int rd, input int r1, input int r2);
    step(0, 1, r1, 1, r2, 1, rd, 1, 0, 0);
  endtask

  task automatic load(input int rd, input int rb);
    step(0, 1, rb, 1, 0, 0, rd, 1, 1, 0);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int cnt_before;

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_d[i] = 0; m_w[i] = 0; m_l[i] = 0;
    end
    m_fa = 0; m_fb = 0; m_cnt = 0;
    reset = 1'b1;
    hf.valido_ID = 1'b0; hf.regR1_ID = '0; hf.regR2_ID = '0; hf.usaR1_ID = 1'b0;
    hf.usaR2_ID = 1'b0; hf.regDest_ID = '0; hf.escreveReg_ID = 1'b0; hf.leMem_ID = 1'b0;
    hf.desvioTomado = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_forwardA", int'(hf.forwardA), 0);
    chk("rst_forwardB", int'(hf.forwardB), 0);
    chk("rst_conta", int'(hf.contaStalls), 0);
    chk("rst_pc", int'(hf.pcEscreve), 1);
    chk("rst_bolha", int'(hf.bolhaEX), 0);
    chk("rst_flush", int'(hf.flushIFID), 0);
    @(negedge clock);

    // ADD r3; SUB r5,r3,r4 back to back
    alu(3, 1, 2);
    alu(5, 3, 4);
    chk("b2b_nostall", s_pc, 1);
    chk("b2b_fwdA", int'(hf.forwardA), 2);
    chk("b2b_fwdB", int'(hf.forwardB), 0);
    nop(); nop(); nop();

    // ADD r3; NOP; SUB r5,r4,r3
    alu(3, 1, 2);
    nop();
    alu(5, 4, 3);
    chk("gap_fwdA", int'(hf.forwardA), 0);
    chk("gap_fwdB", int'(hf.forwardB), 1);
    nop(); nop(); nop();

    // LOAD r2; ADD r6,r2,r2
    load(2, 1);
    alu(6, 2, 2);
    chk("lu_pc", s_pc, 0);
    chk("lu_ifid", s_ifid, 0);
    chk("lu_bolha", s_bolha, 1);
    chk("lu_conta", int'(hf.contaStalls), 1);
    alu(6, 2, 2);
    chk("lu_retry_pc", s_pc, 1);
    chk("lu_fwdA", int'(hf.forwardA), 1);
    chk("lu_fwdB", int'(hf.forwardB), 1);
    nop(); nop(); nop();

    // r0 producer and unused sources never forward or stall
    alu(0, 1, 2);
    alu(5, 0, 0);
    chk("r0_fwdA", int'(hf.forwardA), 0);
    chk("r0_fwdB", int'(hf.forwardB), 0);
    load(7, 1);
    step(0, 1, 7, 0, 7, 0, 8, 1, 0, 0);
    chk("nouse_pc", s_pc, 1);
    chk("nouse_fwdA", int'(hf.forwardA), 0);
    nop(); nop(); nop();

    // Load-use coincident with a taken branch
    cnt_before = int'(hf.contaStalls);
    load(2, 1);
    step(0, 1, 2, 1, 2, 1, 6, 1, 0, 1);
    chk("br_flush", s_flush, 1);
    chk("br_bolha", s_bolha, 1);
    chk("br_pc", s_pc, 1);
    chk("br_conta", int'(hf.contaStalls), cnt_before);
    nop(); nop();

    // Saturate the stall counter
    for (int k = 0; k < CMAX; k++) begin
      load(2, 1);
      alu(6, 2, 2);
      alu(6, 2, 2);
    end
    chk("sat_full", int'(hf.contaStalls), CMAX);
    load(2, 1);
    alu(6, 2, 2);
    chk("sat_stall", s_pc, 0);
    chk("sat_hold", int'(hf.contaStalls), CMAX);

    // Reset asserted during a stall cycle
    load(2, 1);
    step(1, 1, 2, 1, 2, 1, 6, 1, 0, 0);
    chk("midrst_conta", int'(hf.contaStalls), 0);
    chk("midrst_fwdA", int'(hf.forwardA), 0);
    step(0, 1, 2, 1, 2, 1, 6, 1, 0, 0);
    chk("midrst_pc", s_pc, 1);
    chk("midrst_bolha", s_bolha, 0);

    // Random instruction streams over a small register set
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
